instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Multi-cycle fetch/decode/exec sequencer: IDLE -> FETCH -> DECODE -> EXEC, with a sticky HALT state.
// Fetch waits on mem_ready, and exec waits on exec_done. The next PC and retire count update in the exec_done cycle.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        cu_halted,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        Branch,
  input  logic        alu_zero,
  input  logic [31:0] rs_value,
  input  logic        exec_done,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} fetchState_t;

  fetchState_t state;
  logic [31:0] branchOff;
  logic [31:0] branchTgt;
  logic [31:0] jumpTgt;
  logic [31:0] nextPc;
  logic        jrMisaligned;

  assign pc_plus4     = pc + 32'd4;
  assign mem_addr     = pc;
  assign opcode       = inst[31:26];
  assign func         = inst[5:0];
  assign branchOff    = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign branchTgt    = pc_plus4 + branchOff;
  assign jumpTgt      = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign jrMisaligned = JumpReg && (rs_value[1:0] != 2'b00);

  // Redirect priority: register jump beats direct jump beats taken branch.
  always_comb begin
    nextPc = pc_plus4;
    if (JumpReg)
      nextPc = rs_value;
    else if (Jump)
      nextPc = jumpTgt;
    else if (Branch && alu_zero)
      nextPc = branchTgt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      retired    <= 32'h0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      mem_req    <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        FETCH: begin
          if (mem_ready) begin
            inst       <= mem_rdata;
            mem_req    <= 1'b0;
            inst_valid <= 1'b1;
            state      <= DECODE;
          end
        end
        DECODE: begin
          inst_valid <= 1'b0;
          if (cu_halted) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done) begin
            // A misaligned register target stops the core without retiring the instruction.
            if (jrMisaligned) begin
              fault  <= 1'b1;
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc      <= nextPc;
              retired <= retired + 32'd1;
              mem_req <= 1'b1;
              state   <= FETCH;
            end
          end
        end
        HALT: begin
          mem_req    <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mem_req    <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: each fetch request address is checked against a queue of expected PCs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        cu_halted, Jump, JumpReg, Branch, alu_zero;
  logic [31:0] rs_value;
  logic        exec_done;
  logic        halted, fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] mRet = 32'h0;
  logic        prevReq = 1'b0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .inst(inst), .opcode(opcode),
    .func(func), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
    .cu_halted(cu_halted), .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch),
    .alu_zero(alu_zero), .rs_value(rs_value), .exec_done(exec_done),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  // Every new fetch request must match the next expected address.
  always @(negedge clk) begin
    if (mem_req === 1'b1 && prevReq !== 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_fetch: mem_addr=%h, no fetch expected", mem_addr);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        if (mem_addr !== e) begin
          errors++;
          $display("FAIL sb_fetch_addr: got %h expected %h", mem_addr, e);
        end
      end
    end
    prevReq = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic set_garbage();
    cu_halted = 1'b1; JumpReg = 1'b1; Jump = 1'b1; Branch = 1'b1; alu_zero = 1'b1;
    rs_value = 32'h0000_0003;
  endtask

  task automatic apply_reset();
    rst_b = 1'b0;
    mem_ready = 1'b0; exec_done = 1'b0;
    repeat (2) @(negedge clk);
    mRet = 32'h0;
    expQ.push_back(32'h0000_0000);
    rst_b = 1'b1;
  endtask

  task automatic do_instr(input logic [31:0] word, input logic cuH, input logic jr, input logic j,
                          input logic br, input logic z, input logic [31:0] rs, input int memWait,
                          input logic [31:0] expNext, input logic expFault);
    int n;
    logic [31:0] pcBefore;
    mem_ready = 1'b0; exec_done = 1'b1; set_garbage();
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_timeout: mem_req=%b expected 1", mem_req);
    end
    pcBefore = pc;
    repeat (memWait) @(negedge clk);
    mem_ready = 1'b1; mem_rdata = word;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst !== word || opcode !== word[31:26] || func !== word[5:0] || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL decode: valid=%b inst=%h op=%h fn=%h req=%b expected 1/%h/%h/%h/0",
               inst_valid, inst, opcode, func, mem_req, word, word[31:26], word[5:0]);
    end
    mem_rdata = ~word;
    cu_halted = cuH;
    @(negedge clk);
    set_garbage();
    if (cuH) begin
      checks++;
      if (halted !== 1'b1 || inst_valid !== 1'b0 || pc !== pcBefore) begin
        errors++;
        $display("FAIL halt_entry: halted=%b valid=%b pc=%h expected 1/0/%h", halted, inst_valid, pc, pcBefore);
      end
      return;
    end
    checks++;
    if (inst_valid !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL exec_entry: valid=%b halted=%b expected 0/0", inst_valid, halted);
    end
    exec_done = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0; exec_done = 1'b1;
    JumpReg = jr; Jump = j; Branch = br; alu_zero = z; rs_value = rs;
    if (!expFault) expQ.push_back(expNext);
    @(negedge clk);
    exec_done = 1'b0; set_garbage();
    checks++;
    if (expFault) begin
      if (halted !== 1'b1 || fault !== 1'b1 || pc !== pcBefore || retired !== mRet) begin
        errors++;
        $display("FAIL fault_exec: halted=%b fault=%b pc=%h ret=%0d expected 1/1/%h/%0d",
                 halted, fault, pc, retired, pcBefore, mRet);
      end
    end else begin
      mRet = mRet + 32'd1;
      if (pc !== expNext || retired !== mRet || halted !== 1'b0 || inst !== word) begin
        errors++;
        $display("FAIL exec_done: pc=%h ret=%0d halted=%b inst=%h expected %h/%0d/0/%h",
                 pc, retired, halted, inst, expNext, mRet, word);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_b = 1'b0; mem_ready = 1'b0; exec_done = 1'b0; mem_rdata = 32'h0; set_garbage();
    #2;
    checks++;
    if (pc !== 32'h0 || inst !== 32'h0 || retired !== 32'h0 || halted !== 1'b0 || fault !== 1'b0 ||
        mem_req !== 1'b0 || inst_valid !== 1'b0 || opcode !== 6'h0 || func !== 6'h0 || pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_state: pc=%h inst=%h ret=%0d h=%b f=%b req=%b v=%b p4=%h expected 0/0/0/0/0/0/0/4",
               pc, inst, retired, halted, fault, mem_req, inst_valid, pc_plus4);
    end
    repeat (2) @(negedge clk);
    expQ.push_back(32'h0000_0000);
    rst_b = 1'b1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle_req: mem_req=%b expected 0", mem_req);
    end
    n = 0;
    while (mem_req !== 1'b1 && n < 5) begin @(posedge clk); n++; #1; end
    checks++;
    if (n < 1 || n > 2) begin
      errors++; $display("FAIL first_req_edge: edges=%0d expected 1..2", n);
    end
    @(negedge clk);
  endtask

  task automatic test_sequential();
    do_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2, 32'h0000_0004, 1'b0);
  endtask

  task automatic test_branch();
    do_instr(32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 0, 32'h0000_0100, 1'b0);
    do_instr(32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1, 32'h0000_00FC, 1'b0);
    do_instr(32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 0, 32'h0000_0100, 1'b0);
    do_instr(32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 32'h0000_0104, 1'b0);
  endtask

  task automatic test_jump();
    do_instr(32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 0, 32'h1000_0000, 1'b0);
    do_instr(32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1, 32'h1000_0100, 1'b0);
    do_instr(32'h0800_0040, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 0, 32'h0000_0200, 1'b0);
  endtask

  task automatic test_wrap_reset();
    do_instr(32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1'b0);
    checks++;
    if (pc_plus4 !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_pc_plus4: got %h expected 00000000", pc_plus4);
    end
    do_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0000_0000, 1'b0);
    do_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0000_0004, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'hABCD_0020;
    @(negedge clk);
    cu_halted = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    exec_done = 1'b1; mem_ready = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || inst !== 32'h0 || retired !== 32'h0 || halted !== 1'b0 || fault !== 1'b0 ||
        mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h inst=%h ret=%0d h=%b f=%b req=%b v=%b expected all 0",
               pc, inst, retired, halted, fault, mem_req, inst_valid);
    end
    @(negedge clk);
    apply_reset();
    do_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0000_0004, 1'b0);
  endtask

  task automatic test_fault();
    do_instr(32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0203, 0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exec_done = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || pc !== 32'h4 || retired !== 32'h1 || halted !== 1'b1 || fault !== 1'b1) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: req=%b pc=%h ret=%0d h=%b f=%b expected 0/4/1/1/1",
                 i, mem_req, pc, retired, halted, fault);
      end
    end
  endtask

  task automatic test_halt();
    apply_reset();
    #1;
    checks++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL reset_clears_halt: h=%b f=%b expected 0/0", halted, fault);
    end
    do_instr(32'hFC00_003F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exec_done = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0 || retired !== 32'h0 ||
          halted !== 1'b1 || fault !== 1'b0 || inst !== 32'hFC00_003F) begin
        errors++;
        $display("FAIL halt_absorb[%0d]: req=%b v=%b pc=%h ret=%0d h=%b f=%b inst=%h expected 0/0/0/0/1/0/fc00003f",
                 i, mem_req, inst_valid, pc, retired, halted, fault, inst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap_reset();
    test_fault();
    test_halt();
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected fetches never seen, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
